// File: rtl/mem_sram_pkg.sv
// mem_sram_pkg: shared widths, FSM encoding and direction constants for mem_sram
package mem_sram_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic IO_READ = 1'b1;
    localparam logic IO_WRITE = 1'b0;
endpackage

// File: rtl/mem_sram_sram_array.sv
// sram_array: single-port synchronous RAM with registered read data
module sram_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/mem_sram.sv
// mem_sram: request/done handshake FSM in front of a word-addressed SRAM array
module mem_sram
    import mem_sram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH = 2 ** ADDR_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sys_ctr,
    input  logic              sys_io,
    output logic              sys_done,
    input  logic [31:0]       sys_data_addr,
    output logic [DATA_W-1:0] sys_data_rd,
    input  logic [DATA_W-1:0] sys_data_sv
);
    logic [1:0] state, nxt;
    logic io_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q, rdata;
    logic unused_addr;
    assign unused_addr = ^sys_data_addr[31:ADDR_W];
    always_comb begin
        nxt = state == IDLE ? (sys_ctr ? BUSY : IDLE) : state == BUSY ? DONE : IDLE;
    end
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state <= IDLE;
            sys_done <= 1'b1;
            sys_data_rd <= '0;
        end else begin
            state <= nxt;
            sys_done <= nxt == IDLE;
            if (state == DONE && io_q == IO_READ) sys_data_rd <= rdata;
        end
    end
    always_ff @(posedge sys_clk) begin
        if (state == IDLE && sys_ctr) begin
            io_q <= sys_io;
            addr_q <= sys_data_addr[ADDR_W-1:0];
            data_q <= sys_data_sv;
        end
    end
    sram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
        .clk(sys_clk),
        .en(state == BUSY && sys_rst),
        .we(io_q == IO_WRITE),
        .addr(addr_q),
        .wdata(data_q),
        .rdata(rdata)
    );
endmodule

// File: tb/tb_mem_sram.sv
// tb_mem_sram: randomized self-checking bench with an array reference model
module tb_mem_sram;
    logic sys_clk = 0, sys_rst = 0, sys_ctr = 0, sys_io = 0;
    logic sys_done;
    logic [31:0] sys_data_addr = 0, sys_data_rd, sys_data_sv = 0;
    logic [31:0] model [256];
    logic [31:0] exp_rd;
    int tests = 0, fails = 0;

    mem_sram dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_ctr(sys_ctr), .sys_io(sys_io),
        .sys_done(sys_done), .sys_data_addr(sys_data_addr),
        .sys_data_rd(sys_data_rd), .sys_data_sv(sys_data_sv)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic access(input logic io, input logic [31:0] a, input logic [31:0] d,
                          output logic [2:0] seq, output logic [31:0] rd);
        @(negedge sys_clk);
        sys_ctr = 1; sys_io = io; sys_data_addr = a; sys_data_sv = d;
        @(posedge sys_clk); #1 seq[0] = sys_done;
        sys_ctr = 0; sys_io = $urandom(); sys_data_addr = $urandom(); sys_data_sv = $urandom();
        @(posedge sys_clk); #1 seq[1] = sys_done;
        sys_io = $urandom(); sys_data_addr = $urandom(); sys_data_sv = $urandom();
        @(posedge sys_clk); #1 seq[2] = sys_done; rd = sys_data_rd;
        if (io) exp_rd = model[a[7:0]];
        else model[a[7:0]] = d;
    endtask

    task automatic test_reset;
        @(negedge sys_clk); sys_rst = 0;
        @(posedge sys_clk); #1;
        tests++; if (sys_done !== 1'b1) begin fails++; $display("FAIL reset_done got %b want 1", sys_done); end
        tests++; if (sys_data_rd !== 32'd0) begin fails++; $display("FAIL reset_rd got %h want 0", sys_data_rd); end
        @(negedge sys_clk); sys_rst = 1;
        exp_rd = 0;
    endtask

    task automatic test_write;
        logic [2:0] seq; logic [31:0] rd;
        access(0, 10, 17, seq, rd);
        tests++; if (seq !== 3'b100) begin fails++; $display("FAIL write_done_seq got %b want 100", seq); end
        tests++; if (rd !== exp_rd) begin fails++; $display("FAIL write_rd_hold got %h want %h", rd, exp_rd); end
    endtask

    task automatic test_read;
        logic [2:0] seq; logic [31:0] rd;
        access(1, 10, 0, seq, rd);
        tests++; if (seq !== 3'b100) begin fails++; $display("FAIL read_done_seq got %b want 100", seq); end
        tests++; if (rd !== 32'd17) begin fails++; $display("FAIL read_data got %h want 00000011", rd); end
    endtask

    task automatic test_wrap;
        logic [2:0] seq; logic [31:0] rd;
        access(0, 32'h10A, 32'hDEADBEEF, seq, rd);
        tests++; if (rd !== exp_rd) begin fails++; $display("FAIL wrap_write_rd got %h want %h", rd, exp_rd); end
        access(1, 10, 0, seq, rd);
        tests++; if (seq !== 3'b100) begin fails++; $display("FAIL wrap_done_seq got %b want 100", seq); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL wrap_read got %h want deadbeef", rd); end
    endtask

    task automatic test_held;
        logic [2:0] seq; logic [31:0] rd;
        access(0, 20, 32'h2020_0707, seq, rd);
        @(negedge sys_clk);
        sys_ctr = 1; sys_io = 1; sys_data_addr = 10;
        @(posedge sys_clk); #1;
        tests++; if (sys_done !== 1'b0) begin fails++; $display("FAIL held_busy got %b want 0", sys_done); end
        sys_data_addr = 20;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        tests++; if (sys_done !== 1'b1) begin fails++; $display("FAIL held_done1 got %b want 1", sys_done); end
        tests++; if (sys_data_rd !== model[10]) begin fails++; $display("FAIL held_rd1 got %h want %h", sys_data_rd, model[10]); end
        @(posedge sys_clk); #1;
        tests++; if (sys_done !== 1'b0) begin fails++; $display("FAIL held_reaccept got %b want 0", sys_done); end
        sys_ctr = 0;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        tests++; if (sys_done !== 1'b1) begin fails++; $display("FAIL held_done2 got %b want 1", sys_done); end
        tests++; if (sys_data_rd !== model[20]) begin fails++; $display("FAIL held_rd2 got %h want %h", sys_data_rd, model[20]); end
        exp_rd = model[20];
    endtask

    task automatic test_reset_busy;
        logic [2:0] seq; logic [31:0] rd;
        access(0, 5, 32'h55, seq, rd);
        @(negedge sys_clk);
        sys_ctr = 1; sys_io = 0; sys_data_addr = 5; sys_data_sv = 99;
        @(posedge sys_clk); #1;
        tests++; if (sys_done !== 1'b0) begin fails++; $display("FAIL rb_busy got %b want 0", sys_done); end
        @(negedge sys_clk); sys_rst = 0; sys_ctr = 0;
        @(posedge sys_clk); #1;
        tests++; if (sys_done !== 1'b1) begin fails++; $display("FAIL rb_done got %b want 1", sys_done); end
        tests++; if (sys_data_rd !== 32'd0) begin fails++; $display("FAIL rb_rd_clear got %h want 0", sys_data_rd); end
        @(negedge sys_clk); sys_rst = 1;
        exp_rd = 0;
        access(1, 5, 0, seq, rd);
        tests++; if (seq !== 3'b100) begin fails++; $display("FAIL rb_read_seq got %b want 100", seq); end
        tests++; if (rd !== 32'h55) begin fails++; $display("FAIL rb_no_commit got %h want 00000055", rd); end
    endtask

    task automatic test_random;
        logic [2:0] seq; logic [31:0] rd, a, d;
        logic io;
        for (int i = 0; i < 16; i++) begin
            access(0, ($urandom() & 32'hFFFF_FF00) | i, $urandom(), seq, rd);
            tests++; if (rd !== exp_rd) begin fails++; $display("FAIL rnd_fill_rd i=%0d got %h want %h", i, rd, exp_rd); end
        end
        for (int i = 0; i < 60; i++) begin
            io = $urandom();
            a = ($urandom() & 32'hFFFF_FF00) | $urandom_range(0, 15);
            d = $urandom();
            access(io, a, d, seq, rd);
            tests++; if (seq !== 3'b100) begin fails++; $display("FAIL rnd_seq i=%0d got %b want 100", i, seq); end
            tests++; if (rd !== exp_rd) begin fails++; $display("FAIL rnd_rd i=%0d io=%b addr=%h got %h want %h", i, io, a, rd, exp_rd); end
        end
    endtask

    initial begin
        repeat (2) @(posedge sys_clk);
        test_reset;
        test_write;
        test_read;
        test_wrap;
        test_held;
        test_reset_busy;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_sram.md
Name: mem_sram

Overview:
- Word-addressed synchronous data memory for the simple CPU, built as an on-chip SRAM array behind a request/done handshake.
- The CPU core raises a request with a direction bit (read or write), an address and write data. The block performs one access and reports completion on sys_done.
- Read data is registered and held stable until the next read completes.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 8, number of address bits used to index the array.
- DEPTH, 256, number of words (2**ADDR_W).

Ports:
- sys_clk  in  1  clock; all state updates on the rising edge.
- sys_rst  in  1  reset: synchronous, active-low.
- sys_ctr  in  1  request strobe. Level-sensitive: a request is accepted on any rising edge where the FSM is IDLE and sys_ctr=1.
- sys_io  in  1  direction: 1=read, 0=write.
- sys_done  out  1  1 = idle/complete, 0 = access in progress.
- sys_data_addr  in  32  word address; only bits [ADDR_W-1:0] are used.
- sys_data_rd  out  32  read data, registered.
- sys_data_sv  in  32  write data.

Behaviour:
- Reset (sys_rst=0 at a rising edge):
  - FSM goes to IDLE; sys_done=1; sys_data_rd=0.
  - Array contents are not cleared.
  - A reset during BUSY or DONE aborts the access; no write is committed if reset coincides with the BUSY edge.
- FSM states:
  - IDLE: sys_done=1. If sys_ctr=1, latch sys_io, addr[ADDR_W-1:0] and sys_data_sv into internal registers and go to BUSY. Otherwise stay in IDLE.
  - BUSY: sys_done=0. Perform the array access with the latched values:
    - write: mem[addr] <= data;
    - read: sys_data_rd <= mem[addr].
    - Then go to DONE.
  - DONE: sys_done=1; go to IDLE.
- sys_done is a registered output with fixed timing:
  - Accepted at edge N: sys_done=0 after edge N.
  - sys_done=1 again after edge N+2.
  - Write visible to any later read; read data valid on sys_data_rd when sys_done rises.
- Timing of request inputs:
  - Inputs are sampled only at the accepting edge.
  - Changes to sys_io/addr/data while BUSY or DONE are ignored.
- Held request: if sys_ctr stays 1, a new access is accepted on the first IDLE edge, i.e. the request repeats every 3 cycles. Repeated reads and writes are idempotent, so the CPU may hold sys_ctr high.
- sys_ctr=0 in IDLE: no activity, all outputs hold.
- Address bits above ADDR_W-1 are ignored, so addresses wrap modulo DEPTH.
- sys_data_rd changes only on a completed read; a write never alters it.
- Back-to-back write then read to the same address returns the newly written value.
- The array is a single-port inferred RAM, one access per cycle, with no read-during-write hazard because only BUSY touches it.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults;
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - IO_READ=1'b1 and IO_WRITE=1'b0 constants.
- One natural sub-module, sram_array: a single-port synchronous RAM with ports clk, en, we, addr, wdata, rdata. The top holds the FSM, request latches and output register.

Test Plan:
- Reset pulse low for one edge then high → sys_done=1, sys_data_rd=0 within one cycle after release.
- Write 17 to address 10 (sys_io=0, sys_ctr=1) → sys_done goes 0 for 2 cycles then 1; sys_data_rd stays 0.
- Read address 10 (sys_io=1, sys_ctr=1) → sys_done low 2 cycles; on rise sys_data_rd=17.
- Write 0xDEADBEEF to address 266 (0x10A), then read address 10 → read returns 0xDEADBEEF (wrap-around).
- Hold sys_ctr=1 with read of address 10; change sys_data_addr to 20 mid-BUSY → completing read still returns mem[10]; the next accepted read returns mem[20].
- Assert reset during BUSY of a write of 99 to address 5 → sys_done=1 next cycle; a subsequent read of address 5 returns its prior value.
